// File: rtl/fsmc_bus_master.sv
// STM32 FSMC-style asynchronous SRAM bus initiator: turns one-word read/write
// requests into ADDR / DATA / (WHOLD) / TURN bus cycles with registered strobes.
module fsmc_bus_master #(
  parameter int ADRW    = 8,
  parameter int DATW    = 16,
  parameter int ADDSET  = 2,
  parameter int DATAST  = 4,
  parameter int BUSTURN = 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADRW-1:0] req_adr,
  input  logic [DATW-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [DATW-1:0] rsp_rdata,
  output logic            aNE,
  output logic            aNOE,
  output logic            aNWE,
  output logic [ADRW-1:0] aA,
  output logic [DATW-1:0] aD_out,
  output logic            aD_oe,
  input  logic [DATW-1:0] aD_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WHOLD = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  // Phase counters are loaded with (length - 1) and the phase ends when they reach zero.
  localparam logic [3:0] ADDSET_LD = 4'(ADDSET - 1);
  localparam logic [3:0] DATAST_LD = 4'(DATAST - 1);
  localparam logic [3:0] TURN_LD   = (BUSTURN > 0) ? 4'(BUSTURN - 1) : 4'd0;
  localparam logic       HAS_TURN  = (BUSTURN > 0) ? 1'b1 : 1'b0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [ADRW-1:0]   r_adr;
  logic [DATW-1:0]   r_wdata;
  logic              r_ne;
  logic              r_noe;
  logic              r_nwe;
  logic              r_doe;
  logic              r_rsp;
  logic [DATW-1:0]   r_rdata;
  logic              r_ready;

  state_t            w_nxt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;
  logic              w_bus_act;
  logic              w_rd_capture;
  logic              w_rsp_nxt;

  // Next-state and phase-counter logic
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt     = S_ADDR;
          w_cnt_nxt = ADDSET_LD;
        end else begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = 4'd0;
        end
      end
      S_ADDR: begin
        if (r_cnt == 4'd0) begin
          w_nxt     = S_DATA;
          w_cnt_nxt = DATAST_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DATA: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (r_wr) begin
          w_nxt     = S_WHOLD;
          w_cnt_nxt = 4'd0;
        end else if (HAS_TURN) begin
          w_nxt     = S_TURN;
          w_cnt_nxt = TURN_LD;
        end else begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = 4'd0;
        end
      end
      S_WHOLD: begin
        if (HAS_TURN) begin
          w_nxt     = S_TURN;
          w_cnt_nxt = TURN_LD;
        end else begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = 4'd0;
        end
      end
      S_TURN: begin
        if (r_cnt == 4'd0) begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Strobes are registered from the next state so each pin is aligned with its phase.
  assign w_accept     = req_valid & r_ready;
  assign w_bus_act    = (w_nxt == S_ADDR) || (w_nxt == S_DATA) || (w_nxt == S_WHOLD);
  assign w_rd_capture = (r_state == S_DATA) && (r_cnt == 4'd0) && !r_wr;
  assign w_rsp_nxt    = w_rd_capture || (r_state == S_WHOLD);

  // State, request latch and registered bus outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_ne    <= 1'b1;
      r_noe   <= 1'b1;
      r_nwe   <= 1'b1;
      r_doe   <= 1'b0;
      r_rsp   <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr  <= req_write;
        r_adr <= req_adr;
        if (req_write) begin
          r_wdata <= req_wdata;
        end
      end
      r_ne    <= !w_bus_act;
      r_noe   <= !((w_nxt == S_DATA) && !r_wr);
      r_nwe   <= !((w_nxt == S_DATA) && r_wr);
      r_doe   <= r_wr && ((w_nxt == S_DATA) || (w_nxt == S_WHOLD));
      r_rsp   <= w_rsp_nxt;
      if (w_rd_capture) begin
        r_rdata <= aD_in;
      end
      r_ready <= (w_nxt == S_IDLE);
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign aNE       = r_ne;
  assign aNOE      = r_noe;
  assign aNWE      = r_nwe;
  assign aA        = r_adr;
  assign aD_out    = r_wdata;
  assign aD_oe     = r_doe;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Directed cycle-by-cycle bench for fsmc_bus_master: default timing instance plus a
// BUSTURN=0 / ADDSET=1 / DATAST=2 instance, both served by a small SRAM slave model.
module tb_fsmc_bus_master;

  logic        clk = 1'b0;
  logic        nrst;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        req_valid, req_ready, req_write, rsp_valid;
  logic [7:0]  req_adr, aA;
  logic [15:0] req_wdata, rsp_rdata, aD_out, aD_in;
  logic        aNE, aNOE, aNWE, aD_oe;

  // short-timing instance
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
  logic [7:0]  b_req_adr, b_aA;
  logic [15:0] b_req_wdata, b_rsp_rdata, b_aD_out, b_aD_in;
  logic        b_aNE, b_aNOE, b_aNWE, b_aD_oe;

  fsmc_bus_master dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aA(aA),
    .aD_out(aD_out), .aD_oe(aD_oe), .aD_in(aD_in)
  );

  fsmc_bus_master #(.ADDSET(1), .DATAST(2), .BUSTURN(0)) dut_b (
    .clk(clk), .nrst(nrst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_adr(b_req_adr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .aNE(b_aNE), .aNOE(b_aNOE), .aNWE(b_aNWE), .aA(b_aA),
    .aD_out(b_aD_out), .aD_oe(b_aD_oe), .aD_in(b_aD_in)
  );

  // SRAM slave model: drives data only while selected and output-enabled
  logic [15:0] mem [0:255];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      mem[1] <= 16'h1234;
      mem[3] <= 16'hC3A5;
    end else if (!aNE && !aNWE && aD_oe) begin
      mem[aA] <= aD_out;
    end
  end
  assign aD_in   = (!aNE && !aNOE) ? mem[aA] : 16'hxxxx;
  assign b_aD_in = (!b_aNE && !b_aNOE) ? mem[b_aA] : 16'hxxxx;

  // packed observation order: {aNE, aNOE, aNWE, aD_oe, rsp_valid, req_ready}
  logic [5:0] a_stb, b_stb, e_stb;
  assign a_stb = {aNE, aNOE, aNWE, aD_oe, rsp_valid, req_ready};
  assign b_stb = {b_aNE, b_aNOE, b_aNWE, b_aD_oe, b_rsp_valid, b_req_ready};

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  initial begin
    nrst = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_adr = 8'h00; req_wdata = 16'h0000;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_adr = 8'h00; b_req_wdata = 16'h0000;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_stb", 0, 32'(a_stb), 32'(6'b111000));
    chk("rst_aA", 0, 32'(aA), 32'(8'h00));
    chk("rst_dout", 0, 32'(aD_out), 32'(16'h0000));
    chk("rst_rdata", 0, 32'(rsp_rdata), 32'(16'h0000));
    chk("rst_b_stb", 0, 32'(b_stb), 32'(6'b111000));
    nrst = 1'b1; mem_init = 1'b0;
    @(negedge clk);
    chk("idle_ready", 0, 32'(a_stb), 32'(6'b111001));

    // 1: write 0xBEEF to 0x02
    req_valid = 1'b1; req_write = 1'b1; req_adr = 8'h02; req_wdata = 16'hBEEF;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e_stb = {~(k <= 7), 1'b1, ~(k >= 3 && k <= 6), (k >= 3 && k <= 7), (k == 8), (k >= 9)};
      chk("t1_stb", k, 32'(a_stb), 32'(e_stb));
      if (k <= 7) begin
        chk("t1_aA", k, 32'(aA), 32'(8'h02));
        chk("t1_dout", k, 32'(aD_out), 32'(16'hBEEF));
      end
      if (k == 1) req_valid = 1'b0;
    end
    chk("t1_slave_mem", 9, 32'(mem[2]), 32'(16'hBEEF));

    // 2: read 0x01, slave returns 0x1234
    req_valid = 1'b1; req_write = 1'b0; req_adr = 8'h01; req_wdata = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e_stb = {~(k <= 6), ~(k >= 3 && k <= 6), 1'b1, 1'b0, (k == 7), (k >= 8)};
      chk("t2_stb", k, 32'(a_stb), 32'(e_stb));
      if (k == 7) chk("t2_rdata", k, 32'(rsp_rdata), 32'(16'h1234));
      if (k == 1) req_valid = 1'b0;
    end

    // 3+6: write 0x00AB to 0x02 with request held and inputs changed while busy,
    // then the held read of 0x02 starts only once req_ready is back
    req_valid = 1'b1; req_write = 1'b1; req_adr = 8'h02; req_wdata = 16'h00AB;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      e_stb = {~((k <= 7) || (k >= 10 && k <= 15)), ~(k >= 12 && k <= 15),
               ~(k >= 3 && k <= 6), (k >= 3 && k <= 7), (k == 8 || k == 16), (k == 9 || k >= 17)};
      chk("t3_stb", k, 32'(a_stb), 32'(e_stb));
      if ((k <= 7) || (k >= 10 && k <= 15)) chk("t3_aA", k, 32'(aA), 32'(8'h02));
      if (k <= 7) chk("t3_dout", k, 32'(aD_out), 32'(16'h00AB));
      if (k == 16) chk("t3_rdata", k, 32'(rsp_rdata), 32'(16'h00AB));
      if (k == 1) begin
        req_write = 1'b0; req_adr = 8'h77; req_wdata = 16'hFFFF;
      end
      if (k == 5) req_adr = 8'h02;
      if (k == 10) req_valid = 1'b0;
    end

    // 4: short timing, two held reads back-to-back
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_adr = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e_stb = {~((k <= 3) || (k >= 5 && k <= 7)), ~((k >= 2 && k <= 3) || (k >= 6 && k <= 7)),
               1'b1, 1'b0, (k == 4 || k == 8), (k == 4 || k >= 8)};
      chk("t4_stb", k, 32'(b_stb), 32'(e_stb));
      if (k == 4) chk("t4_rdata0", k, 32'(b_rsp_rdata), 32'(16'h1234));
      if (k == 8) chk("t4_rdata1", k, 32'(b_rsp_rdata), 32'(16'hC3A5));
      if (k == 1) b_req_adr = 8'h03;
      if (k == 5) b_req_valid = 1'b0;
    end

    // 5: reset in the second DATA cycle of a write aborts it
    req_valid = 1'b1; req_write = 1'b1; req_adr = 8'h04; req_wdata = 16'h5A5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    chk("t5_in_data", 4, 32'(a_stb), 32'(6'b010100));
    nrst = 1'b0;
    #1;
    chk("t5_abort_now", 4, 32'(a_stb), 32'(6'b111000));
    @(negedge clk);
    chk("t5_abort_held", 5, 32'(a_stb), 32'(6'b111000));
    nrst = 1'b1;
    rsp_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rsp_cnt += int'(rsp_valid);
    end
    chk("t5_no_rsp", 0, 32'(rsp_cnt), 32'(0));
    chk("t5_idle", 0, 32'(a_stb), 32'(6'b111001));

    req_valid = 1'b1; req_write = 1'b0; req_adr = 8'h02;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e_stb = {~(k <= 6), ~(k >= 3 && k <= 6), 1'b1, 1'b0, (k == 7), (k >= 8)};
      chk("t5_rd_stb", k, 32'(a_stb), 32'(e_stb));
      if (k == 7) chk("t5_rd_rdata", k, 32'(rsp_rdata), 32'(16'h00AB));
      if (k == 1) req_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
